iq_quadrature_demodulator: RTL and testbench

Downstream consumer of the 8 kHz sine/cosine LUT generator. Mixes an incoming signed sample stream with the generator's sinus/cosinus words and integrate-and-dumps over ACC_LEN accepted samples, which is one LUT period by default. It produces baseband I/Q pairs for the downstream magnitude/phase stage. It is a 3-stage pipeline with a sticky saturation flag.

---
 rtl/iq_quadrature_demodulator.sv | 99 +++++++++
 tb/tb_iq_quadrature_demodulator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/iq_quadrature_demodulator.sv
// iq_quadrature_demodulator: mixes a sample stream with LO sine/cosine words and
// integrate-and-dumps ACC_LEN accepted products into baseband I/Q pairs.
module iq_quadrature_demodulator #(
   parameter int DATA_W  = 16,
   parameter int LO_W    = 32,
   parameter int LO_FRAC = 30,
   parameter int ACC_LEN = 32,
   parameter int OUT_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          sample_in,
   input  logic                       in_valid,
   input  logic [LO_W-1:0]            sinus,
   input  logic [LO_W-1:0]            cosinus,
   input  logic                       clr,
   output logic [OUT_W-1:0]           i_out,
   output logic [OUT_W-1:0]           q_out,
   output logic                       out_valid,
   output logic                       overflow,
   output logic [$clog2(ACC_LEN)-1:0] frame_pos
);
   localparam int MW = DATA_W + LO_W;
   localparam int PW = MW - LO_FRAC;
   localparam int CW = $clog2(ACC_LEN);
   localparam int AW = PW + CW;

   logic signed [DATA_W-1:0] s1;
   logic signed [LO_W-1:0]   sin1, cos1;
   logic signed [MW-1:0]     p_i, p_q;
   logic signed [AW-1:0]     acc_i, acc_q, sum_i, sum_q;
   logic [OUT_W-1:0]         cv_i, cv_q;
   logic                     v1, v2, ov, dump;

   always_ff @(posedge clk) begin
      s1   <= sample_in;
      sin1 <= sinus;
      cos1 <= cosinus;
      p_i  <= MW'(s1) * MW'(cos1);
      p_q  <= MW'(s1) * MW'(sin1);
   end

   // arithmetic shift floors; the truncating cast keeps the sign since the result fits in PW bits
   assign sum_i = acc_i + AW'(p_i >>> LO_FRAC);
   assign sum_q = acc_q + AW'(p_q >>> LO_FRAC);
   assign dump  = v2 && frame_pos == CW'(ACC_LEN - 1);

   generate
      if (AW > OUT_W) begin : g_sat
         logic ov_i, ov_q;
         assign ov_i = sum_i[AW-1:OUT_W-1] != {(AW-OUT_W+1){sum_i[AW-1]}};
         assign ov_q = sum_q[AW-1:OUT_W-1] != {(AW-OUT_W+1){sum_q[AW-1]}};
         assign cv_i = ov_i ? {sum_i[AW-1], {(OUT_W-1){~sum_i[AW-1]}}} : sum_i[OUT_W-1:0];
         assign cv_q = ov_q ? {sum_q[AW-1], {(OUT_W-1){~sum_q[AW-1]}}} : sum_q[OUT_W-1:0];
         assign ov   = ov_i | ov_q;
      end else begin : g_ext
         assign cv_i = OUT_W'(sum_i);
         assign cv_q = OUT_W'(sum_q);
         assign ov   = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         acc_i <= '0;
         acc_q <= '0;
         frame_pos <= '0;
         out_valid <= 1'b0;
         overflow <= 1'b0;
         i_out <= '0;
         q_out <= '0;
      end else if (clr) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         acc_i <= '0;
         acc_q <= '0;
         frame_pos <= '0;
         out_valid <= 1'b0;
      end else begin
         v1 <= in_valid;
         v2 <= v1;
         out_valid <= dump;
         if (dump) begin
            i_out <= cv_i;
            q_out <= cv_q;
            overflow <= overflow | ov;
            acc_i <= '0;
            acc_q <= '0;
            frame_pos <= '0;
         end else if (v2) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            frame_pos <= frame_pos + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_iq_quadrature_demodulator.sv
// tb_iq_quadrature_demodulator: scoreboard bench driving a 32-bit-output and a
// 16-bit-output (saturating) demodulator with the same stimulus.
module tb_iq_quadrature_demodulator;
   localparam int ONE = 1 << 30;
   localparam int LEN = 32;

   logic        clk = 0, rst_n = 0, in_valid = 0, clr = 0;
   logic [15:0] sample_in = '0;
   logic [31:0] sinus = '0, cosinus = '0;
   logic [31:0] i_a, q_a;
   logic [15:0] i_b, q_b;
   logic        ov_a, ov_b, of_a, of_b;
   logic [4:0]  fp_a, fp_b;

   typedef struct {int due; longint iv; longint qv;} exp_t;
   exp_t q[$];

   int     edge_cnt = 0, checks = 0, errs = 0, cnt = 0;
   longint si = 0, sq = 0;
   int     cnt_hist[4096];
   bit     kill_hist[4096], rst_hist[4096];

   iq_quadrature_demodulator dut_a (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .in_valid(in_valid),
      .sinus(sinus), .cosinus(cosinus), .clr(clr), .i_out(i_a), .q_out(q_a),
      .out_valid(ov_a), .overflow(of_a), .frame_pos(fp_a));

   iq_quadrature_demodulator #(.OUT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .in_valid(in_valid),
      .sinus(sinus), .cosinus(cosinus), .clr(clr), .i_out(i_b), .q_out(q_b),
      .out_valid(ov_b), .overflow(of_b), .frame_pos(fp_b));

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string n, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", n, edge_cnt, act, exp);
      end
   endtask

   function automatic longint sat16(input longint v);
      return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
   endfunction

   // Model: a frame is ACC_LEN accepted samples; its result appears two edges after the last one.
   task automatic drive(input bit v, input int s, input int sn, input int cs,
                        input bit c = 0, input bit r = 0);
      int t;
      rst_n = !r;
      clr = c;
      in_valid = v;
      sample_in = 16'(s);
      sinus = sn;
      cosinus = cs;
      t = edge_cnt + 1;
      if (r || c) begin
         while (q.size() > 0 && q[$].due >= t) void'(q.pop_back());
         cnt = 0;
         si = 0;
         sq = 0;
      end else if (v) begin
         si += (longint'(s) * longint'(cs)) >>> 30;
         sq += (longint'(s) * longint'(sn)) >>> 30;
         cnt++;
         if (cnt == LEN) begin
            q.push_back('{t + 2, si, sq});
            cnt = 0;
            si = 0;
            sq = 0;
         end
      end
      cnt_hist[t] = cnt;
      kill_hist[t] = r || c;
      rst_hist[t] = r;
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      int   k;
      exp_t e;
      bit   exp_v, exp_of16;
      exp_of16 = 0;
      forever begin
         @(negedge clk);
         k = edge_cnt;
         if (k >= 1 && rst_hist[k]) begin
            exp_of16 = 0;
            chk("rst_i_a", $signed(i_a), 0);
            chk("rst_q_b", $signed(q_b), 0);
            chk("rst_valid_a", ov_a, 0);
            chk("rst_ovf_b", of_b, 0);
            chk("rst_fp_a", fp_a, 0);
         end else if (k >= 3) begin
            exp_v = q.size() > 0 && q[0].due == k;
            chk("valid_a", ov_a, exp_v);
            chk("valid_b", ov_b, exp_v);
            if (exp_v) begin
               e = q.pop_front();
               chk("i32", $signed(i_a), e.iv);
               chk("q32", $signed(q_a), e.qv);
               chk("ovf32", of_a, 0);
               exp_of16 |= (sat16(e.iv) != e.iv) || (sat16(e.qv) != e.qv);
               chk("i16", $signed(i_b), sat16(e.iv));
               chk("q16", $signed(q_b), sat16(e.qv));
               chk("ovf16", of_b, exp_of16);
            end
            chk("frame_pos_a", fp_a, (kill_hist[k] || kill_hist[k-1]) ? 0 : cnt_hist[k-2]);
            chk("frame_pos_b", fp_b, (kill_hist[k] || kill_hist[k-1]) ? 0 : cnt_hist[k-2]);
         end
      end
   end

   initial begin
      int mn;
      mn = int'(32'h8000_0000);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < LEN; i++) drive(1, 1000, ONE, 0);
      repeat (5) drive(0, 0, 0, 0);
      for (int i = 0; i < 2 * LEN; i++) drive(i % 2 == 0, -1, 0, 1);
      repeat (4) drive(0, 0, 0, 0);
      for (int i = 0; i < LEN; i++) drive(1, 32767, 0, ONE);
      for (int i = 0; i < LEN; i++) drive(1, 0, 0, ONE);
      repeat (4) drive(0, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 100, 0, ONE);
      drive(1, 100, 0, ONE, 1, 0);
      for (int i = 0; i < LEN; i++) drive(1, 100, 0, ONE);
      repeat (4) drive(0, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 100, 0, ONE);
      drive(1, 100, 0, ONE, 0, 1);
      for (int i = 0; i < LEN; i++) drive(1, 100, 0, ONE);
      for (int i = 0; i < 2 * LEN; i++) drive(1, i < LEN ? 50 : -50, 0, ONE);
      for (int i = 0; i < LEN; i++) drive(1, int'($urandom_range(0, 65535)) - 32768, mn, mn);
      for (int i = 0; i < 800; i++)
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom), int'($urandom), $urandom_range(0, 63) == 0);
      repeat (10) drive(0, 0, 0, 0);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end
endmodule
